// File: rtl/dsp_mac_stream_ctrl_if.sv
// Operand/result handshake bundle for dsp_mac_stream_ctrl.
// master = producer/consumer side, slave = the MAC controller.
interface dsp_mac_stream_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic [47:0] in_c;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_p;
  logic        out_sat;

  modport master (
    output in_valid, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_p, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_p, out_sat
  );
endinterface

// File: rtl/dsp_mac_stream_ctrl.sv
// Streaming P = A*B + C front-end: 3-stage pipeline, output FIFO, credit flow control.
// Optional saturation of the 49-bit sum to 48 bits when DSP_MAC_SAT_EN is defined. DEPTH legal range 4..64.
module dsp_mac_stream_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  dsp_mac_stream_ctrl_if.slave bus,
  output logic                 busy,
  output logic [31:0]          result_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
`ifdef DSP_MAC_SAT_EN
  localparam int EW = 49;
`else
  localparam int EW = 48;
`endif

  logic              rstn_q;
  logic [CW-1:0]     credits;
  logic              accept;
  logic              pop;

  logic              s1_v, s2_v, s3_v;
  logic signed [17:0] s1_a, s1_b;
  logic [47:0]       s1_c;
  logic signed [35:0] s2_prod;
  logic [48:0]       s2_c;
  logic [48:0]       sum;
  logic [EW-1:0]     s3_next;
  logic [EW-1:0]     s3_ent;

  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              empty;
  logic [EW-1:0]     head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;
  // Credits cover every in-flight and queued result, so the FIFO cannot overflow.
  assign bus.in_ready = (credits != '0) && rstn_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstn_q  <= 1'b0;
      credits <= CW'(DEPTH);
    end else begin
      rstn_q <= 1'b1;
      if (accept && !pop)
        credits <= credits - CW'(1);
      else if (!accept && pop)
        credits <= credits + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      s1_v <= accept;
      s2_v <= s1_v;
      s3_v <= s2_v;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_a <= bus.in_a;
      s1_b <= bus.in_b;
      s1_c <= bus.in_c;
    end
    s2_prod <= s1_a * s1_b;
    s2_c    <= {s1_c[47], s1_c};
    s3_ent  <= s3_next;
  end

  always_comb begin
    sum     = {{13{s2_prod[35]}}, s2_prod} + s2_c;
    s3_next = '0;
`ifdef DSP_MAC_SAT_EN
    // Bits 48 and 47 disagree only when the true sum does not fit in 48 bits.
    if (sum[48] != sum[47])
      s3_next = sum[48] ? {1'b1, 48'h8000_0000_0000} : {1'b1, 48'h7FFF_FFFF_FFFF};
    else
      s3_next = {1'b0, sum[47:0]};
`else
    s3_next = sum[47:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (s3_v)
      mem[wr_ptr] <= s3_ent;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      result_cnt <= '0;
    end else begin
      if (s3_v)
        wr_ptr <= ptr_next(wr_ptr);
      if (pop) begin
        rd_ptr     <= ptr_next(rd_ptr);
        result_cnt <= result_cnt + 32'd1;
      end
      if (s3_v && !pop)
        count <= count + CW'(1);
      else if (!s3_v && pop)
        count <= count - CW'(1);
    end
  end

  assign empty         = (count == '0);
  assign head          = mem[rd_ptr];
  assign bus.out_valid = !empty;
  assign bus.out_p     = empty ? '0 : head[47:0];
`ifdef DSP_MAC_SAT_EN
  assign bus.out_sat   = empty ? 1'b0 : head[48];
`else
  assign bus.out_sat   = 1'b0;
`endif

  assign busy = s1_v || s2_v || s3_v || !empty;

endmodule

// File: tb/tb_dsp_mac_stream_ctrl.sv
// Directed self-checking bench for dsp_mac_stream_ctrl (DEPTH = 8).
// Expected results for the saturation vector follow DSP_MAC_SAT_EN.
module tb_dsp_mac_stream_ctrl;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        busy;
  logic [31:0] result_cnt;

  always #5 clk = ~clk;

  dsp_mac_stream_ctrl_if ifc ();

  dsp_mac_stream_ctrl #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (ifc),
    .busy       (busy),
    .result_cnt (result_cnt)
  );

  int          checks = 0;
  int          errors = 0;
  int          tick_no = 0;
  int          first_acc = -1;
  int          last_pop = -1;
  logic [48:0] expq[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] model(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c);
    logic signed [48:0] s;
    s = $signed(a) * $signed(b) + $signed(c);
`ifdef DSP_MAC_SAT_EN
    if (s > 49'sh0_7FFF_FFFF_FFFF) return {1'b1, 48'h7FFF_FFFF_FFFF};
    if (s < -49'sh0_8000_0000_0000) return {1'b1, 48'h8000_0000_0000};
`endif
    return {1'b0, s[47:0]};
  endfunction

  // Called at a falling edge: predicts what the next rising edge does, checks any pop, advances.
  task automatic tick(output bit acc);
    logic [48:0] e;
    acc = rstn && ifc.in_valid && ifc.in_ready;
    if (acc && first_acc < 0) first_acc = tick_no;
    if (rstn && ifc.out_valid && ifc.out_ready) begin
      last_pop = tick_no;
      if (expq.size() == 0) begin
        check("pop_without_expected", ifc.out_valid, 0);
      end else begin
        e = expq.pop_front();
        check("out_p", ifc.out_p, e[47:0]);
        check("out_sat", ifc.out_sat, e[48]);
      end
    end
    tick_no++;
    @(negedge clk);
  endtask

  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
                      input logic [48:0] e, output int waited);
    bit acc;
    acc = 0;
    waited = 0;
    ifc.in_a = a;
    ifc.in_b = b;
    ifc.in_c = c;
    ifc.in_valid = 1'b1;
    while (!acc && waited < 64) begin
      tick(acc);
      waited++;
      if (acc) expq.push_back(e);
    end
    if (!acc) check("send_timeout_in_ready", ifc.in_ready, 1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 200) begin
      tick(acc);
      n++;
    end
    check("drain_pending", expq.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    bit          acc;
    int          w;
    int          n_acc;
    int          stalls;
    int          seen;
    logic [17:0] ra, rb;
    logic [47:0] rc;

    rstn = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_c      = '0;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    tick(acc);
    tick(acc);

    check("rst_in_ready", ifc.in_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_p", ifc.out_p, 0);
    check("rst_out_sat", ifc.out_sat, 0);
    check("rst_busy", busy, 0);
    check("rst_result_cnt", result_cnt, 0);

    rstn = 1'b1;
    check("in_ready_before_release_edge", ifc.in_ready, 0);
    tick(acc);
    check("in_ready_after_release_edge", ifc.in_ready, 1);

    // Basic back-to-back triples; accept edges k, k+1, k+2
    send(18'd2,   18'd3,   48'd1,   49'd7,    w);
    send(18'd100, 18'd10,  48'd5,   49'd1005, w);
    send(18'd0,   18'd999, 48'd123, 49'd123,  w);
    check("lat_after_k2_out_valid", ifc.out_valid, 0);
    tick(acc);
    check("lat_after_k3_out_valid", ifc.out_valid, 1);
    check("lat_first_out_p", ifc.out_p, 48'd7);
    drain();
    check("cnt_basic", result_cnt, 3);

    // Signed vectors
    send(18'h3FFFB, 18'd7,     48'd0,               {1'b0, 48'hFFFF_FFFF_FFDD}, w);
    send(18'h20000, 18'h20000, 48'hFFFF_FFFF_FFFF,  {1'b0, 48'h0003_FFFF_FFFF}, w);
    drain();
    check("cnt_signed", result_cnt, 5);

    // Positive overflow of the 48-bit result
`ifdef DSP_MAC_SAT_EN
    send(18'd131071, 18'd131071, 48'h7FFF_FFFF_FFFF, {1'b1, 48'h7FFF_FFFF_FFFF}, w);
`else
    send(18'd131071, 18'd131071, 48'h7FFF_FFFF_FFFF, {1'b0, 48'h8003_FFFC_0000}, w);
`endif
    drain();
    check("cnt_sat", result_cnt, 6);

    // Backpressure: consumer stalled, producer holds in_valid
    ifc.out_ready = 1'b0;
    ifc.in_b      = 18'd1;
    ifc.in_c      = '0;
    ifc.in_valid  = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      ifc.in_a = 18'(n_acc);
      tick(acc);
      if (acc) begin
        expq.push_back(49'(n_acc));
        n_acc++;
      end
    end
    ifc.in_valid = 1'b0;
    check("bp_accept_count", n_acc, 8);
    check("bp_in_ready_low", ifc.in_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_out_valid", ifc.out_valid, 1);
    ifc.out_ready = 1'b1;
    tick(acc);
    check("bp_in_ready_after_first_pop", ifc.in_ready, 1);
    drain();
    check("cnt_bp", result_cnt, 14);

    // Sustained throughput with random operands
    first_acc = -1;
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 18'($urandom);
      rb = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)};
      send(ra, rb, rc, model(ra, rb, rc), w);
      if (w != 1) stalls++;
    end
    drain();
    check("tp_stalls", stalls, 0);
    check("tp_span_first_accept_to_last_pop", last_pop - first_acc, 103);
    check("cnt_tp", result_cnt, 114);

    // Reset with 3 results in flight and 2 queued
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send(18'(i + 1), 18'd5, 48'd9, model(18'(i + 1), 18'd5, 48'd9), w);
    check("pre_rst_out_valid", ifc.out_valid, 1);
    check("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    tick(acc);
    check("midrst_out_valid", ifc.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_result_cnt", result_cnt, 0);
    check("midrst_in_ready", ifc.in_ready, 0);
    expq.delete();
    rstn = 1'b1;
    ifc.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ifc.out_valid || busy) seen++;
      tick(acc);
    end
    check("no_stale_after_reset", seen, 0);
    send(18'd2, 18'd3, 48'd1, 49'd7, w);
    drain();
    check("cnt_after_reset", result_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
